// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the Minisys-style MIPS execute-stage ALU:
//   - datapath width
//   - I-type opcode and R-type funct encodings handled by the ALU
//   - ALUOp encodings driven by the main decoder
//   - internal operation enum produced by alu_control
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_WIDTH = 32;

    // I-type ALU opcodes (001xxx)
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // R-type funct codes
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    // ALUOp from the main decoder; 2'b11 is unused and behaves like MEM (add)
    localparam logic [1:0] ALUOP_MEM  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI,
        ALU_ZERO
    } alu_op_e;

endpackage

// File: rtl/mips_alu_if.sv
// ----------------------------------------------------------------------------
// mips_alu_if
// Bundle of the ALU's operand, control and result signals.
//   master : the decode side (drives operands/controls, observes results)
//   slave  : the ALU itself
// Signals: Read_A, Read_B, Read_I, Shamt, ALUSrc, I_format, opcode, funct,
//          ALUOp (to ALU); ALU_Result, Zero, debug (from ALU).
// ----------------------------------------------------------------------------
interface mips_alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] Read_A;
    logic [WIDTH-1:0] Read_B;
    logic [WIDTH-1:0] Read_I;
    logic [4:0]       Shamt;
    logic             ALUSrc;
    logic             I_format;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [1:0]       ALUOp;
    logic [WIDTH-1:0] ALU_Result;
    logic             Zero;
    logic [WIDTH-1:0] debug;

    modport master (
        output Read_A, Read_B, Read_I, Shamt, ALUSrc, I_format, opcode, funct, ALUOp,
        input  ALU_Result, Zero, debug
    );

    modport slave (
        input  Read_A, Read_B, Read_I, Shamt, ALUSrc, I_format, opcode, funct, ALUOp,
        output ALU_Result, Zero, debug
    );
endinterface

// File: rtl/alu_control.sv
// ----------------------------------------------------------------------------
// alu_control
// Decodes ALUOp / I_format / opcode / funct into the internal ALU operation.
// Ports:
//   ALUOp, I_format, opcode, funct : decoder inputs
//   op        : operation to perform
//   shift_var : 1 -> shift amount comes from A[4:0] (sllv/srlv/srav)
//   zero_ext  : 1 -> operand B is zero-extended from its low 16 bits
// ----------------------------------------------------------------------------
module alu_control
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic       I_format,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_e    op,
    output logic       shift_var,
    output logic       zero_ext
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        op        = ALU_ZERO;
        shift_var = 1'b0;
        zero_ext  = 1'b0;

        unique case (ALUOp)
            ALUOP_BR: op = ALU_SUB;
            ALUOP_FUNC: begin
                if (I_format) begin
                    case (opcode)
                        OP_ADDI, OP_ADDIU: op = ALU_ADD;
                        OP_SLTI:           op = ALU_SLT;
                        OP_SLTIU:          op = ALU_SLTU;
                        OP_ANDI: begin op = ALU_AND; zero_ext = 1'b1; end
                        OP_ORI:  begin op = ALU_OR;  zero_ext = 1'b1; end
                        OP_XORI: begin op = ALU_XOR; zero_ext = 1'b1; end
                        OP_LUI:            op = ALU_LUI;
                        default:           op = ALU_ZERO;
                    endcase
                end else begin
                    case (funct)
                        F_ADD, F_ADDU: op = ALU_ADD;
                        F_SUB, F_SUBU: op = ALU_SUB;
                        F_AND:         op = ALU_AND;
                        F_OR:          op = ALU_OR;
                        F_XOR:         op = ALU_XOR;
                        F_NOR:         op = ALU_NOR;
                        F_SLT:         op = ALU_SLT;
                        F_SLTU:        op = ALU_SLTU;
                        F_SLL:         op = ALU_SLL;
                        F_SRL:         op = ALU_SRL;
                        F_SRA:         op = ALU_SRA;
                        F_SLLV: begin op = ALU_SLL; shift_var = 1'b1; end
                        F_SRLV: begin op = ALU_SRL; shift_var = 1'b1; end
                        F_SRAV: begin op = ALU_SRA; shift_var = 1'b1; end
                        // jr produces no ALU result
                        default:       op = ALU_ZERO;
                    endcase
                end
            end
            // ALUOP_MEM and the unused 2'b11 both add
            default: op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_alu.sv
// ----------------------------------------------------------------------------
// mips_alu
// Execute-stage ALU of the single-cycle MIPS CPU.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset; clears only the debug register
//   bus  : mips_alu_if.slave -- operands/controls in; ALU_Result and Zero
//          (combinational) plus debug (ALU_Result registered each clk) out
// ----------------------------------------------------------------------------
module mips_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
)(
    input  logic        clk,
    input  logic        rst,
    mips_alu_if.slave   bus
);

    alu_op_e          op;
    logic             shift_var;
    logic             zero_ext;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] debug_q;

    alu_control u_control (
        .ALUOp     (bus.ALUOp),
        .I_format  (bus.I_format),
        .opcode    (bus.opcode),
        .funct     (bus.funct),
        .op        (op),
        .shift_var (shift_var),
        .zero_ext  (zero_ext)
    );

    assign a     = bus.Read_A;
    assign b_sel = bus.ALUSrc ? bus.Read_I : bus.Read_B;
    // andi/ori/xori use the raw 16-bit immediate, not the sign-extended one
    assign b     = zero_ext ? {{(WIDTH-16){1'b0}}, b_sel[15:0]} : b_sel;
    assign shamt = shift_var ? a[4:0] : bus.Shamt;

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
            ALU_LUI:  result = {b[15:0], {(WIDTH-16){1'b0}}};
            default:  result = '0;
        endcase
    end

    assign bus.ALU_Result = result;
    assign bus.Zero       = (result == '0);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!rst) debug_q <= '0;
        else      debug_q <= result;
    end

    assign bus.debug = debug_q;

endmodule

// File: tb/tb_mips_alu.sv
// ----------------------------------------------------------------------------
// tb_mips_alu
// Directed self-checking bench for mips_alu with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_mips_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    mips_alu_if #(.WIDTH(32)) bus ();

    mips_alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a full operation at the falling edge, then settle.
    task automatic drive(input logic [1:0] aluop, input logic ifmt, input logic [5:0] opc,
                         input logic [5:0] fn, input logic src, input logic [31:0] ra,
                         input logic [31:0] rb, input logic [31:0] ri, input logic [4:0] sh);
        @(negedge clk);
        bus.ALUOp    = aluop;
        bus.I_format = ifmt;
        bus.opcode   = opc;
        bus.funct    = fn;
        bus.ALUSrc   = src;
        bus.Read_A   = ra;
        bus.Read_B   = rb;
        bus.Read_I   = ri;
        bus.Shamt    = sh;
        #1;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [31:0] ra, input logic [31:0] rb,
                         input logic [4:0] sh, input string tag, input logic [31:0] exp);
        drive(ALUOP_FUNC, 1'b0, 6'b000000, fn, 1'b0, ra, rb, 32'h0, sh);
        check(tag, bus.ALU_Result, exp);
    endtask

    task automatic itype(input logic [5:0] opc, input logic [31:0] ra, input logic [31:0] ri,
                         input string tag, input logic [31:0] exp);
        drive(ALUOP_FUNC, 1'b1, opc, 6'b000000, 1'b1, ra, 32'h0, ri, 5'd0);
        check(tag, bus.ALU_Result, exp);
    endtask

    initial begin
        logic [31:0] held;

        // Reset state
        drive(ALUOP_MEM, 1'b0, 6'b0, 6'b0, 1'b0, 32'd3, 32'd4, 32'd0, 5'd0);
        check("reset_debug", bus.debug, 32'h0);
        check("comb_in_reset", bus.ALU_Result, 32'd7);
        @(negedge clk);
        rst = 1'b1;

        // addi sweep with one-cycle debug latency
        for (int i = 0; i <= 1000; i++) begin
            drive(ALUOP_FUNC, 1'b1, OP_ADDI, 6'b0, 1'b1, i, 32'h0, 32'd12, 5'd0);
            check("addi", bus.ALU_Result, i + 12);
            @(posedge clk);
            #1;
            check("addi_debug", bus.debug, i + 12);
        end

        // wrap
        itype(OP_ADDI, 32'hFFFF_FFF8, 32'd12, "addi_wrap", 32'h0000_0004);
        check("addi_wrap_zero", {31'b0, bus.Zero}, 32'd0);

        // beq / bne subtract and Zero
        drive(ALUOP_BR, 1'b0, 6'b000100, 6'b0, 1'b0, 32'h1234, 32'h1234, 32'h0, 5'd0);
        check("beq_eq", bus.ALU_Result, 32'h0);
        check("beq_eq_zero", {31'b0, bus.Zero}, 32'd1);
        drive(ALUOP_BR, 1'b0, 6'b000100, 6'b0, 1'b0, 32'h1234, 32'h1235, 32'h0, 5'd0);
        check("beq_ne", bus.ALU_Result, 32'hFFFF_FFFF);
        check("beq_ne_zero", {31'b0, bus.Zero}, 32'd0);

        // memory address add, ALUOp=11 also adds
        drive(ALUOP_MEM, 1'b0, 6'b100011, 6'b0, 1'b1, 32'd100, 32'd0, 32'hFFFF_FFFC, 5'd0);
        check("lw_addr", bus.ALU_Result, 32'd96);
        drive(2'b11, 1'b0, 6'b0, 6'b0, 1'b0, 32'd3, 32'd4, 32'd0, 5'd0);
        check("aluop11_add", bus.ALU_Result, 32'd7);

        // R-type arithmetic / logic
        rtype(F_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, "slt",  32'd1);
        rtype(F_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, "sltu", 32'd0);
        rtype(F_SUBU, 32'd5, 32'd7, 5'd0, "subu", 32'hFFFF_FFFE);
        rtype(F_ADD,  32'h7FFF_FFFF, 32'd1, 5'd0, "add_wrap", 32'h8000_0000);
        rtype(F_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, "and", 32'h00F0_1234);
        rtype(F_OR,   32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, "or",  32'hFFF0_FFFF);
        rtype(F_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, "xor", 32'hFF00_EDCB);
        rtype(F_NOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, "nor", 32'h000F_0000);

        // Shifts
        rtype(F_SLL,  32'd0,  32'h8000_0010, 5'd4, "sll",  32'h0000_0100);
        rtype(F_SRL,  32'd0,  32'h8000_0010, 5'd4, "srl",  32'h0800_0001);
        rtype(F_SRA,  32'd0,  32'h8000_0010, 5'd4, "sra",  32'hF800_0001);
        rtype(F_SRAV, 32'd36, 32'h8000_0010, 5'd0, "srav", 32'hF800_0001);
        rtype(F_SLLV, 32'd36, 32'h8000_0010, 5'd0, "sllv", 32'h0000_0100);
        rtype(F_SRLV, 32'd36, 32'h8000_0010, 5'd9, "srlv", 32'h0800_0001);
        rtype(F_SLL,  32'd0,  32'hDEAD_BEEF, 5'd0, "sll_zero_amt", 32'hDEAD_BEEF);
        rtype(F_SRA,  32'd0,  32'h8000_0000, 5'd31, "sra_31", 32'hFFFF_FFFF);

        // Zero-result functs
        rtype(F_JR,      32'h1234, 32'h5678, 5'd0, "jr", 32'h0);
        rtype(6'b111111, 32'h1234, 32'h5678, 5'd0, "bad_funct", 32'h0);
        check("bad_funct_zero", {31'b0, bus.Zero}, 32'd1);

        // I-type table
        itype(OP_SLTI,  32'hFFFF_FFFF, 32'd5, "slti",  32'd1);
        itype(OP_SLTIU, 32'hFFFF_FFFF, 32'd5, "sltiu", 32'd0);
        itype(OP_ANDI,  32'hFFFF_FFFF, 32'hFFFF_ABCD, "andi", 32'h0000_ABCD);
        itype(OP_XORI,  32'hFFFF_FFFF, 32'hFFFF_ABCD, "xori", 32'hFFFF_5432);
        itype(6'b000000, 32'd5, 32'd5, "bad_opcode", 32'h0);

        // lui / ori, then async reset between edges
        itype(OP_LUI, 32'h1111_1111, 32'hFFFF_ABCD, "lui", 32'hABCD_0000);
        itype(OP_ORI, 32'h0, 32'hFFFF_ABCD, "ori", 32'h0000_ABCD);
        @(posedge clk);
        #1;
        check("ori_debug", bus.debug, 32'h0000_ABCD);
        held = bus.ALU_Result;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_debug", bus.debug, 32'h0);
        check("async_rst_result", bus.ALU_Result, 32'h0000_ABCD);
        @(posedge clk);
        #1;
        check("rst_hold_debug", bus.debug, 32'h0);
        check("rst_result_stable", bus.ALU_Result, held);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_debug", bus.debug, 32'h0000_ABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Execute-stage ALU of the single-cycle MIPS (Minisys-style) CPU.
- Sits between the decoder/register file and memory/writeback.
- Selects operand B (register or extended immediate) and decodes the operation from ALUOp, funct or opcode.
- Produces a combinational 32-bit result plus zero flag; also keeps a registered copy of the result for board debug.

Parameters:
- WIDTH, 32, datapath width (only 32 supported).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; clears the debug register only.
- Read_A  in  32  operand A (rs data).
- Read_B  in  32  rt data, used when ALUSrc=0.
- Read_I  in  32  sign-extended immediate from decoder, used when ALUSrc=1.
- Shamt  in  5  instruction shamt field.
- ALUSrc  in  1  1 selects Read_I as operand B; 0 selects Read_B.
- I_format  in  1  1 means the instruction is an I-type ALU op (opcode 001xxx).
- opcode  in  6  instruction opcode.
- funct  in  6  instruction funct field.
- ALUOp  in  2  00 add (lw/sw), 01 sub (beq/bne), 10 decode funct/opcode, 11 treated as add.
- ALU_Result  out  32  combinational result.
- Zero  out  1  combinational; 1 when ALU_Result == 0.
- debug  out  32  ALU_Result registered on each clk rising edge.

Behaviour:
- B = ALUSrc ? Read_I : Read_B.
- Decode priority: ALUOp=00 or 11 -> A+B; ALUOp=01 -> A-B; ALUOp=10 with I_format=1 -> opcode table; ALUOp=10 with I_format=0 -> funct table.
- Funct table (R-type):
  - 100000/100001 add/addu -> A+B.
  - 100010/100011 sub/subu -> A-B.
  - 100100 and -> A&B; 100101 or -> A|B; 100110 xor -> A^B; 100111 nor -> ~(A|B).
  - 101010 slt -> signed A<B ? 1 : 0; 101011 sltu -> unsigned compare, same encoding.
  - 000000 sll -> B<<Shamt; 000010 srl -> B>>Shamt (logical); 000011 sra -> B>>>Shamt (arithmetic).
  - 000100 sllv / 000110 srlv / 000111 srav -> same three shifts with amount A[4:0].
  - 001000 jr -> 0.
  - Any other funct -> 0.
- Opcode table (I-type; ALUSrc is 1 in normal use, but the B mux is still honoured):
  - 001000 addi / 001001 addiu -> A+B.
  - 001010 slti -> signed A<B; 001011 sltiu -> unsigned A<B.
  - 001100 andi / 001101 ori / 001110 xori -> A op {16'b0, B[15:0]} (zero-extended).
  - 001111 lui -> {B[15:0], 16'b0}.
  - Any other opcode -> 0.
- Arithmetic wraps modulo 2^32; no overflow trap, no overflow output.
- slt results are exactly 32'h0 or 32'h1.
- Shift amounts use only 5 bits; amount 0 passes B through unchanged.
- Zero is derived from the final ALU_Result, including for the sub used by beq/bne.
- ALU_Result and Zero are purely combinational, same-cycle, unaffected by rst.
- debug: on rst low -> 32'h0 immediately (async). Otherwise it captures ALU_Result on every rising clk; latency is one cycle.
- Reset asserted mid-operation clears debug only; combinational outputs keep tracking their inputs.

Decomposition:
- Shared package alu_pkg:
  - localparams for opcodes (OP_ADDI … OP_LUI) and funct codes (F_ADD … F_SRAV).
  - ALUOp encodings (ALUOP_MEM=00, ALUOP_BR=01, ALUOP_FUNC=10).
  - An internal operation enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, ZERO).
- Sub-module alu_control: maps ALUOp/I_format/opcode/funct to the operation enum plus two selects (shift-variable, zero-extend).
- mips_alu: operand mux, datapath and debug register.

Test Plan:
- addi: ALUOp=10, I_format=1, opcode=001000, ALUSrc=1, Read_I=12. Read_A = 0, 1, 2 … 1000 -> ALU_Result = Read_A+12 each step; debug matches one clk later.
- wrap: same setup, Read_A=32'hFFFF_FFF8 -> ALU_Result=32'h4, Zero=0.
- beq: ALUOp=01, ALUSrc=0, Read_A=Read_B=32'h1234 -> ALU_Result=0, Zero=1. Read_B=32'h1235 -> 32'hFFFF_FFFF, Zero=0.
- slt vs sltu: R-type, A=32'hFFFF_FFFF, B=1. funct 101010 -> 1; funct 101011 -> 0.
- shifts: B=32'h8000_0010, Shamt=4. sll -> 32'h0000_0100; srl -> 32'h0800_0001; sra -> 32'hF800_0001. srav with A=36 shifts by 4 and gives the same result as sra.
- lui/ori and reset: lui with Read_I=32'hFFFF_ABCD -> 32'hABCD_0000. ori with A=0 and the same Read_I -> 32'h0000_ABCD. Assert rst=0 between clk edges -> debug=0 immediately while ALU_Result is unchanged.
